// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the FFT output stream.
// Ping-pong banks: one frame is written in bit-reversed address order while the
// other is read out sequentially through a 2-entry output skid register.
module fft_bitrev_reorder #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned FFT_N    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [2*SAMPLE_W-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [2*SAMPLE_W-1:0] m_data,
  output logic                  m_last
);

  localparam int unsigned LOG2_N = $clog2(FFT_N);
  localparam int unsigned DATA_W = 2 * SAMPLE_W;
  localparam int unsigned ADDR_W = LOG2_N + 1;
  localparam int unsigned MEM_D  = 2 * FFT_N;
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(FFT_N - 1);

  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] a);
    logic [LOG2_N-1:0] r;
    for (int i = 0; i < int'(LOG2_N); i++) r[i] = a[int'(LOG2_N) - 1 - i];
    return r;
  endfunction

  logic [DATA_W-1:0] mem [MEM_D];
  logic [DATA_W-1:0] ram_rdata_q;

  logic [LOG2_N-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic              rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic [1:0]        sk_cnt_q, sk_cnt_d;
  logic [DATA_W-1:0] sk0_data_q, sk0_data_d, sk1_data_q, sk1_data_d;
  logic              sk0_last_q, sk0_last_d, sk1_last_q, sk1_last_d;

  logic              wr_en, wr_done, rd_en, rd_done, pop;
  logic [1:0]        occ;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  // Handshake, bank-release and read-issue decisions
  always_comb begin
    s_ready = ~full_q[wr_bank_q];
    wr_en   = s_valid & s_ready;
    wr_done = wr_en & (wr_cnt_q == LAST_IDX);
    wr_addr = {wr_bank_q, bitrev(wr_cnt_q)};
    pop     = (sk_cnt_q != 2'd0) & m_ready;
    // Skid entries plus the read in flight must never exceed two slots
    occ     = sk_cnt_q + 2'(rd_vld_q);
    rd_en   = full_q[rd_bank_q] & ((occ < 2'd2) | ((occ == 2'd2) & pop));
    rd_done = rd_en & (rd_cnt_q == LAST_IDX);
    rd_addr = {rd_bank_q, rd_cnt_q};
  end

  // Write/read counters, bank pointers and per-bank full flags
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    rd_vld_d  = rd_en;
    rd_last_d = rd_done;
    if (wr_en) wr_cnt_d = wr_cnt_q + LOG2_N'(1);
    if (wr_done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rd_en) rd_cnt_d = rd_cnt_q + LOG2_N'(1);
    if (rd_done) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // Output skid: entry 0 drives the port, entry 1 absorbs data under backpressure
  always_comb begin
    sk_cnt_d   = sk_cnt_q;
    sk0_data_d = sk0_data_q;
    sk0_last_d = sk0_last_q;
    sk1_data_d = sk1_data_q;
    sk1_last_d = sk1_last_q;
    unique case ({rd_vld_q, pop})
      2'b01: begin
        sk0_data_d = sk1_data_q;
        sk0_last_d = sk1_last_q;
        sk1_last_d = 1'b0;
        sk_cnt_d   = sk_cnt_q - 2'd1;
      end
      2'b10: begin
        if (sk_cnt_q == 2'd0) begin
          sk0_data_d = ram_rdata_q;
          sk0_last_d = rd_last_q;
        end else begin
          sk1_data_d = ram_rdata_q;
          sk1_last_d = rd_last_q;
        end
        sk_cnt_d = sk_cnt_q + 2'd1;
      end
      2'b11: begin
        if (sk_cnt_q == 2'd1) begin
          sk0_data_d = ram_rdata_q;
          sk0_last_d = rd_last_q;
        end else begin
          sk0_data_d = sk1_data_q;
          sk0_last_d = sk1_last_q;
          sk1_data_d = ram_rdata_q;
          sk1_last_d = rd_last_q;
        end
      end
      default: ;
    endcase
  end

  assign m_valid = (sk_cnt_q != 2'd0);
  assign m_data  = sk0_data_q;
  assign m_last  = sk0_last_q;

  // Ping-pong RAM with one write port and a registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= s_data;
    if (rd_en) ram_rdata_q <= mem[rd_addr];
  end

  // Control and skid state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      sk_cnt_q   <= '0;
      sk0_data_q <= '0;
      sk0_last_q <= 1'b0;
      sk1_data_q <= '0;
      sk1_last_q <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      sk_cnt_q   <= sk_cnt_d;
      sk0_data_q <= sk0_data_d;
      sk0_last_q <= sk0_last_d;
      sk1_data_q <= sk1_data_d;
      sk1_last_q <= sk1_last_d;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: ordering, latency, throughput,
// backpressure, random handshakes and mid-operation reset.
module tb_fft_bitrev_reorder;

  localparam int unsigned SW = 16;
  localparam int unsigned N  = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [2*SW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [2*SW-1:0] m_data;
  logic          m_last;

  int tests_run    = 0;
  int tests_failed = 0;
  int in_cnt  = 0;
  int out_cnt = 0;
  int cyc     = 0;
  int stall_cnt = 0;
  int first_out = -1;
  int last_out  = -1;

  fft_bitrev_reorder #(.SAMPLE_W(SW), .FFT_N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < 8; i++) if (((k >> i) & 1) == 1) r |= (1 << (7 - i));
    return r;
  endfunction

  // Bin b of frame f: real = f*256+b, imag = -real
  function automatic logic [31:0] bin_val(input int f, input int b);
    logic [15:0] re;
    logic [15:0] im;
    re = 16'(f * 256 + b);
    im = -re;
    return {re, im};
  endfunction

  // Input sequence number -> value presented in bit-reversed order
  function automatic logic [31:0] in_val(input int seq);
    return bin_val(seq / 256, brev(seq % 256));
  endfunction

  // Called at a falling edge: drive, observe the coming edge's handshakes, advance
  task automatic step(input bit sv, input bit mr);
    s_valid = sv;
    m_ready = mr;
    s_data  = sv ? in_val(in_cnt) : 32'($urandom);
    #1;
    if (sv && !s_ready) stall_cnt++;
    if (s_valid && s_ready) in_cnt++;
    if (m_valid && m_ready) begin
      check("m_data", m_data, bin_val(out_cnt / 256, out_cnt % 256));
      check("m_last", 32'(m_last), 32'((out_cnt % 256) == 255));
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      out_cnt++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 3000 && out_cnt < in_cnt; c++) step(1'b0, 1'b1);
    check(tag, 32'(out_cnt), 32'(in_cnt));
  endtask

  initial begin
    int s;
    int t;
    int k;
    logic [31:0] held;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single frame in natural order out
    for (int c = 0; c < 2000 && out_cnt < 256; c++) step(in_cnt < 256, 1'b1);
    check("t1_outputs", 32'(out_cnt), 32'd256);
    check("t1_idle_m_valid", 32'(m_valid), 32'd0);

    // 2: latency from last input handshake
    for (int c = 0; c < 1000 && (in_cnt % 256) != 255; c++) step(1'b1, 1'b1);
    s_valid = 1'b1;
    m_ready = 1'b0;
    s_data  = in_val(in_cnt);
    #1;
    check("t2_s_ready", 32'(s_ready), 32'd1);
    in_cnt++;
    @(negedge clk);
    s_valid = 1'b0;
    #1 check("t2_e0_m_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    #1 check("t2_e1_m_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    #1 check("t2_e2_m_valid", 32'(m_valid), 32'd1);
    check("t2_e2_bin0", m_data, bin_val(out_cnt / 256, 0));
    @(negedge clk);
    drain("t2_drain");

    // 3: four frames back-to-back at full rate
    s = in_cnt;
    stall_cnt = 0;
    first_out = -1;
    for (int c = 0; c < 3000 && out_cnt < s + 1024; c++) step(in_cnt < s + 1024, 1'b1);
    check("t3_no_stall", 32'(stall_cnt), 32'd0);
    check("t3_outputs", 32'(out_cnt - s), 32'd1024);
    check("t3_contiguous", 32'(last_out - first_out), 32'd1023);

    // 4: backpressure fills both banks
    s = in_cnt;
    for (int c = 0; c < 600; c++) step(1'b1, 1'b0);
    check("t4_accepted", 32'(in_cnt - s), 32'd512);
    check("t4_s_ready", 32'(s_ready), 32'd0);
    check("t4_m_valid", 32'(m_valid), 32'd1);
    check("t4_head", m_data, bin_val(out_cnt / 256, 0));
    held = m_data;
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0);
    check("t4_held", m_data, held);
    t = out_cnt;
    for (int c = 0; c < 400 && !s_ready; c++) step(1'b0, 1'b1);
    k = out_cnt - t;
    check("t4_release_window", 32'(k >= 254 && k <= 256), 32'd1);
    drain("t4_drain");

    // 5: random handshakes on both sides
    s = in_cnt;
    for (int c = 0; c < 60000 && out_cnt < s + 20 * 256; c++)
      step((in_cnt < s + 20 * 256) && ($urandom_range(1, 0) == 1), $urandom_range(1, 0) == 1);
    check("t5_outputs", 32'(out_cnt - s), 32'(20 * 256));
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
    check("t5_no_extra", 32'(m_valid), 32'd0);

    // 6: reset mid-operation
    s = in_cnt;
    for (int c = 0; c < 800 && in_cnt < s + 356; c++) step(1'b1, 1'b0);
    t = out_cnt;
    for (int c = 0; c < 100 && out_cnt < t + 10; c++) step(1'b0, 1'b1);
    check("t6_pre_outputs", 32'(out_cnt - t), 32'd10);
    rst_n = 1'b0;
    #1;
    check("t6_rst_m_valid", 32'(m_valid), 32'd0);
    check("t6_rst_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    in_cnt  = ((in_cnt + 255) / 256) * 256;
    out_cnt = in_cnt;
    @(negedge clk);
    s = in_cnt;
    for (int c = 0; c < 2000 && out_cnt < s + 256; c++) step(in_cnt < s + 256, 1'b1);
    check("t6_outputs", 32'(out_cnt - s), 32'd256);
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1);
    check("t6_no_stale", 32'(m_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
